// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter.
// master: the block that drives enable/up_down/load/load_value and observes the count.
// slave : the counter itself (consumes the controls, drives gray_out/bin_out/terminal/wrap_evt).
interface gray_updown_counter_if #(
  parameter int N = 4
);
  logic         enable;
  logic         up_down;
  logic         load;
  logic [N-1:0] load_value;
  logic [N-1:0] gray_out;
  logic [N-1:0] bin_out;
  logic         terminal;
  logic         wrap_evt;

  modport master (
    output enable, up_down, load, load_value,
    input  gray_out, bin_out, terminal, wrap_evt
  );

  modport slave (
    input  enable, up_down, load, load_value,
    output gray_out, bin_out, terminal, wrap_evt
  );
endinterface

// File: rtl/gray_updown_counter.sv
// N-bit Gray up/down counter with synchronous load and wrap-or-saturate ends.
// Latency: gray_out updates one clk edge after a sampled load/enable; bin_out and terminal follow combinationally.
// Backpressure: none; enable is the only throttle and the block is always ready.
// Ports: clk, reset (async, active-high), bus (slave modport): enable, up_down, load, load_value in;
//        gray_out, bin_out, terminal, wrap_evt out.
module gray_updown_counter #(
  parameter int N    = 4,
  parameter bit WRAP = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  gray_updown_counter_if.slave  bus
);

  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] g_q;
  logic [N-1:0] g_nxt;
  logic [N-1:0] b;
  logic         evt_q;
  logic         evt_nxt;
  logic         at_max;
  logic         at_min;

  function automatic logic [N-1:0] to_gray(input logic [N-1:0] v);
    return v ^ (v >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at and above it; computing it
  // per bit avoids a bit-to-bit dependency chain inside one vector.
  always_comb begin
    b = '0;
    for (int i = 0; i < N; i++) begin
      b[i] = ^(g_q >> i);
    end
  end

  assign at_max = &b;
  assign at_min = ~|b;

  // Plain N-bit +1/-1 already produces the wrap targets (0 going up, 2^N-1
  // going down), so the ends only need special handling when saturating.
  always_comb begin
    g_nxt   = g_q;
    evt_nxt = 1'b0;
    if (bus.load) begin
      g_nxt = bus.load_value;
    end else if (bus.enable) begin
      if (bus.up_down) begin
        evt_nxt = at_max;
        if (!(at_max && !WRAP)) begin
          g_nxt = to_gray(b + ONE);
        end
      end else begin
        evt_nxt = at_min;
        if (!(at_min && !WRAP)) begin
          g_nxt = to_gray(b - ONE);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_q   <= '0;
      evt_q <= 1'b0;
    end else begin
      g_q   <= g_nxt;
      evt_q <= evt_nxt;
    end
  end

  assign bus.gray_out = g_q;
  assign bus.bin_out  = b;
  assign bus.terminal = bus.up_down ? at_max : at_min;
  assign bus.wrap_evt = evt_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Bench for gray_updown_counter: four instances (N=4 wrap, N=4 saturate, N=2 wrap, N=8 wrap)
// checked against a binary-count reference model; Gray values are derived from the model count.
module tb_gray_updown_counter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gray_updown_counter_if #(.N(4)) ifa ();
  gray_updown_counter_if #(.N(4)) ifb ();
  gray_updown_counter_if #(.N(2)) ifc ();
  gray_updown_counter_if #(.N(8)) ifd ();

  gray_updown_counter #(.N(4), .WRAP(1'b1)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  gray_updown_counter #(.N(4), .WRAP(1'b0)) dut_b (.clk(clk), .reset(reset), .bus(ifb));
  gray_updown_counter #(.N(2), .WRAP(1'b1)) dut_c (.clk(clk), .reset(reset), .bus(ifc));
  gray_updown_counter #(.N(8), .WRAP(1'b1)) dut_d (.clk(clk), .reset(reset), .bus(ifd));

  int npass  = 0;
  int ntotal = 0;

  // Reference model state per instance: binary count, expected event, expected bit changes.
  int unsigned mb[4];
  bit          me[4];
  int          hexp[4];
  logic [31:0] prev_g[4];
  bit          ien[4], iud[4], ild[4];
  int unsigned ilv[4];

  function automatic int nw(int id);
    case (id)
      2:       return 2;
      3:       return 8;
      default: return 4;
    endcase
  endfunction

  function automatic bit wr(int id);
    return id != 1;
  endfunction

  function automatic int unsigned maxv(int id);
    return (32'd1 << nw(id)) - 32'd1;
  endfunction

  function automatic int unsigned gray_of(int unsigned v);
    return v ^ (v >> 1);
  endfunction

  // Decode by search: the count whose Gray image equals g.
  function automatic int unsigned gray_decode(int id, int unsigned g);
    for (int unsigned v = 0; v <= maxv(id); v++) begin
      if (gray_of(v) == g) return v;
    end
    return 0;
  endfunction

  task automatic chk(string tag, int id, logic [31:0] obs, logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s dut%0d: got %0h expected %0h", tag, id, obs, exp);
  endtask

  task automatic drive(int id, bit en, bit ud, bit ld, logic [31:0] lv);
    ien[id] = en; iud[id] = ud; ild[id] = ld; ilv[id] = lv & maxv(id);
    case (id)
      0: begin ifa.enable = en; ifa.up_down = ud; ifa.load = ld; ifa.load_value = lv[3:0]; end
      1: begin ifb.enable = en; ifb.up_down = ud; ifb.load = ld; ifb.load_value = lv[3:0]; end
      2: begin ifc.enable = en; ifc.up_down = ud; ifc.load = ld; ifc.load_value = lv[1:0]; end
      default: begin ifd.enable = en; ifd.up_down = ud; ifd.load = ld; ifd.load_value = lv[7:0]; end
    endcase
  endtask

  task automatic get(int id, output logic [31:0] g, output logic [31:0] b,
                     output logic [31:0] t, output logic [31:0] e);
    case (id)
      0: begin g = 32'(ifa.gray_out); b = 32'(ifa.bin_out); t = 32'(ifa.terminal); e = 32'(ifa.wrap_evt); end
      1: begin g = 32'(ifb.gray_out); b = 32'(ifb.bin_out); t = 32'(ifb.terminal); e = 32'(ifb.wrap_evt); end
      2: begin g = 32'(ifc.gray_out); b = 32'(ifc.bin_out); t = 32'(ifc.terminal); e = 32'(ifc.wrap_evt); end
      default: begin g = 32'(ifd.gray_out); b = 32'(ifd.bin_out); t = 32'(ifd.terminal); e = 32'(ifd.wrap_evt); end
    endcase
  endtask

  task automatic model_reset(int id);
    mb[id] = 0; me[id] = 1'b0; hexp[id] = -1;
  endtask

  // One rising edge of the reference model, from the inputs held over the edge.
  task automatic model_step(int id);
    int unsigned b;
    b = mb[id];
    if (ild[id]) begin
      mb[id] = gray_decode(id, ilv[id]); me[id] = 1'b0; hexp[id] = -1;
    end else if (ien[id] && iud[id]) begin
      if (b == maxv(id)) begin
        me[id] = 1'b1;
        if (wr(id)) begin mb[id] = 0; hexp[id] = 1; end
        else hexp[id] = 0;
      end else begin
        mb[id] = b + 1; me[id] = 1'b0; hexp[id] = 1;
      end
    end else if (ien[id]) begin
      if (b == 0) begin
        me[id] = 1'b1;
        if (wr(id)) begin mb[id] = maxv(id); hexp[id] = 1; end
        else hexp[id] = 0;
      end else begin
        mb[id] = b - 1; me[id] = 1'b0; hexp[id] = 1;
      end
    end else begin
      me[id] = 1'b0; hexp[id] = 0;
    end
  endtask

  task automatic check_dut(string tag, int id);
    logic [31:0] g, b, t, e;
    bit term_exp;
    get(id, g, b, t, e);
    term_exp = iud[id] ? (mb[id] == maxv(id)) : (mb[id] == 0);
    chk({tag, ".gray"}, id, g, gray_of(mb[id]));
    chk({tag, ".bin"}, id, b, mb[id]);
    chk({tag, ".terminal"}, id, t, 32'(term_exp));
    chk({tag, ".wrap_evt"}, id, e, 32'(me[id]));
    if (hexp[id] >= 0) chk({tag, ".hamming"}, id, 32'($countones(g ^ prev_g[id])), 32'(hexp[id]));
    prev_g[id] = g;
  endtask

  task automatic tick(string tag);
    @(posedge clk);
    #1;
    for (int id = 0; id < 4; id++) begin
      if (reset) model_reset(id);
      else model_step(id);
      check_dut(tag, id);
    end
  endtask

  logic [3:0] up_seq[17];

  initial begin
    up_seq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
               4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
    for (int id = 0; id < 4; id++) begin
      prev_g[id] = '0;
      model_reset(id);
    end

    // Power-on reset; dut1 counts down so its terminal must read 1 at zero.
    reset = 1'b1;
    drive(0, 1'b0, 1'b1, 1'b0, 0);
    drive(1, 1'b0, 1'b0, 1'b0, 0);
    drive(2, 1'b0, 1'b1, 1'b0, 0);
    drive(3, 1'b0, 1'b1, 1'b0, 0);
    tick("reset");
    tick("reset");
    reset = 1'b0;

    // Count up a few steps, then reset asynchronously between edges.
    drive(0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 5; i++) tick("pre_rst");
    reset = 1'b1;
    #1;
    for (int id = 0; id < 4; id++) begin
      model_reset(id);
      check_dut("async_rst", id);
    end
    drive(0, 1'b0, 1'b1, 1'b0, 0);
    #2 reset = 1'b0;

    // Full up cycle on N=4 wrap, against the literal Gray sequence.
    drive(0, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 1; i <= 16; i++) begin
      tick("up_cycle");
      chk("up_seq.gray", 0, 32'(ifa.gray_out), 32'(up_seq[i]));
      chk("up_seq.wrap_evt", 0, 32'(ifa.wrap_evt), 32'(i == 16));
      chk("up_seq.terminal", 0, 32'(ifa.terminal), 32'(up_seq[i] == 4'h8));
    end

    // Down wrap from zero, then reverse back up through the wrap.
    drive(0, 1'b1, 1'b0, 1'b0, 0);
    tick("down_wrap");
    chk("down_wrap.gray", 0, 32'(ifa.gray_out), 32'h8);
    chk("down_wrap.evt", 0, 32'(ifa.wrap_evt), 32'h1);
    drive(0, 1'b1, 1'b1, 1'b0, 0);
    tick("rev_wrap");
    chk("rev_wrap.gray", 0, 32'(ifa.gray_out), 32'h0);
    chk("rev_wrap.evt", 0, 32'(ifa.wrap_evt), 32'h1);
    drive(0, 1'b0, 1'b1, 1'b0, 0);

    // Saturate mode at both ends.
    drive(1, 1'b0, 1'b1, 1'b1, 32'h8);
    tick("sat_load");
    drive(1, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      tick("sat_top");
      chk("sat_top.gray", 1, 32'(ifb.gray_out), 32'h8);
      chk("sat_top.evt", 1, 32'(ifb.wrap_evt), 32'h1);
    end
    drive(1, 1'b0, 1'b0, 1'b1, 32'h0);
    tick("sat_load0");
    drive(1, 1'b1, 1'b0, 1'b0, 0);
    tick("sat_bot");
    chk("sat_bot.gray", 1, 32'(ifb.gray_out), 32'h0);
    chk("sat_bot.evt", 1, 32'(ifb.wrap_evt), 32'h1);
    drive(1, 1'b0, 1'b0, 1'b0, 0);

    // Load wins over a simultaneous enable.
    drive(0, 1'b0, 1'b1, 1'b1, 32'h6);
    tick("ld_pre");
    drive(0, 1'b1, 1'b1, 1'b1, 32'hB);
    tick("ld_prio");
    chk("ld_prio.gray", 0, 32'(ifa.gray_out), 32'hB);
    chk("ld_prio.bin", 0, 32'(ifa.bin_out), 32'd13);
    chk("ld_prio.evt", 0, 32'(ifa.wrap_evt), 32'h0);
    drive(0, 1'b1, 1'b1, 1'b0, 0);
    tick("ld_next");
    chk("ld_next.gray", 0, 32'(ifa.gray_out), 32'h9);

    // Hold with enable low.
    drive(0, 1'b0, 1'b1, 1'b1, 32'h5);
    tick("hold_ld");
    drive(0, 1'b0, 1'b0, 1'b0, 32'hF);
    for (int i = 0; i < 5; i++) begin
      tick("hold");
      chk("hold.gray", 0, 32'(ifa.gray_out), 32'h5);
      chk("hold.evt", 0, 32'(ifa.wrap_evt), 32'h0);
    end

    // Full up cycles on N=2 and N=8.
    drive(2, 1'b1, 1'b1, 1'b0, 0);
    drive(3, 1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i <= 256; i++) begin
      if (i == 5) drive(2, 1'b0, 1'b1, 1'b0, 0);
      tick("sweep_up");
    end

    // Random traffic on all instances.
    for (int i = 0; i < 400; i++) begin
      for (int id = 0; id < 4; id++) begin
        drive(id, $urandom_range(0, 9) < 7, 1'($urandom), $urandom_range(0, 9) == 0, $urandom);
      end
      tick("random");
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised N-bit Gray-code counter with up/down direction, synchronous parallel load, and a selectable wrap or saturate mode at the terminal values.
- Outputs the registered Gray count, its binary equivalent, a terminal-count flag and a one-cycle wrap/saturation event pulse.
- Next-generation counter for the Gray counter family. Used for multi-clock-domain pointers and low-toggle position counters.

Parameters:
- N, 4: counter width in bits; legal range 2..32.
- WRAP, 1: 1 = modulo-2^N wrap at the ends; 0 = saturate at the ends.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- enable  input  1  count enable, sampled on the rising edge of clk
- up_down  input  1  1 = count up, 0 = count down; sampled only when enable=1
- load  input  1  synchronous load strobe
- load_value  input  N  Gray-coded value to load; every N-bit pattern is legal
- gray_out  output  N  registered Gray count
- bin_out  output  N  binary equivalent of gray_out (combinational from the register)
- terminal  output  1  combinational; 1 when the next count step in the current direction would wrap or saturate
- wrap_evt  output  1  registered; one-cycle pulse after a wrap or saturation-hold step

Behaviour:
- Only state is the N-bit Gray register G plus the wrap_evt flop. B = gray-to-binary(G), where B[N-1] = G[N-1] and B[i] = B[i+1] ^ G[i].
- Reset asynchronously forces G = 0 and wrap_evt = 0. Hence gray_out = 0, bin_out = 0, and terminal = ~up_down (at B=0, counting down is terminal).
- Priority on each rising edge: reset > load > enable > hold.
- load=1: G <= load_value, wrap_evt <= 0. Applies regardless of enable and up_down.
- enable=1, load=0, up_down=1:
  - B < 2^N-1: G <= bin-to-gray(B+1).
  - B = 2^N-1 (G = 1 followed by N-1 zeros):
    - WRAP=1: G <= 0, wrap_evt <= 1.
    - WRAP=0: G holds, wrap_evt <= 1.
- enable=1, load=0, up_down=0:
  - B > 0: G <= bin-to-gray(B-1).
  - B = 0:
    - WRAP=1: G <= 1 followed by N-1 zeros, wrap_evt <= 1.
    - WRAP=0: G holds, wrap_evt <= 1.
- In every other enabled step, wrap_evt <= 0. When enable=0 and load=0, G holds and wrap_evt <= 0.
- Latency: gray_out changes one clock edge after the sampled enable or load. bin_out and terminal follow gray_out combinationally in the same cycle.
- Hamming property: every enabled, non-saturated, non-load step changes exactly one bit of gray_out, including both wrap steps. Saturated holds change zero bits. Loads may change any number of bits.
- Direction reversal is allowed on any cycle; the next step uses the newly sampled up_down.
- Reset mid-count takes effect immediately, without a clock edge, and overrides a simultaneous load or enable.
- Arithmetic is modulo 2^N. Internal +1/-1 is N bits wide with no carry-out port.
- No X propagation from load_value when load=0.

Test Plan:
- Reset behaviour, N=4, WRAP=1: reset=1 mid-count with enable=1 and up_down=1 -> gray_out=0000, bin_out=0, wrap_evt=0 immediately; terminal=0.
- Full up sequence, N=4, WRAP=1: 16 enabled up steps from 0 -> gray_out = 0000,0001,0011,0010,0110,0111,0101,0100,1100,1101,1111,1110,1010,1011,1001,1000, then 0000.
  - terminal=1 while gray_out=1000.
  - wrap_evt=1 for exactly the one cycle after the 1000->0000 step.
  - Exactly one bit changes on every step.
- Down wrap and reversal, N=4, WRAP=1: from 0000 step down -> 1000 (bin 15) with wrap_evt pulse; then up_down=1 step -> 0000, wrap_evt=1 again.
- Saturate mode, N=4, WRAP=0:
  - At 1000, enable up 3 cycles -> gray_out stays 1000, wrap_evt=1 each cycle.
  - At 0000, enable down -> stays 0000, wrap_evt=1.
- Load priority, N=4: at gray_out=0110 apply load=1, load_value=1011, enable=1, up_down=1 -> next gray_out=1011, bin_out=13, wrap_evt=0; next up step -> 1001.
- Hold and width sweep: enable=0 for 5 cycles at 0101 -> no change, wrap_evt=0. Repeat the full-cycle and one-bit-change check for N=2 and N=8 with random enable, up_down and load -> outputs match a binary reference model converted to Gray.
